// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer.
// One full-adder cell is reused across WIDTH cycles, LSB first. Operands
// enter through a valid/ready handshake. The result leaves through a second
// valid/ready handshake and is held stable until it is taken.

module serial_add_full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Operand shift registers. Bit 0 of each feeds the adder on every RUN cycle.
  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  // Partial result. Sum bits enter at the MSB. The lowest slot is not
  // stored, because the final edge writes the full word straight into sum_reg.
  logic [WIDTH-1:1] result_reg;
  logic [WIDTH-1:0] result_next;
  logic             carry_reg;
  logic [CNT_W-1:0] count_reg;

  // Registered outputs. These change only when an operation completes.
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic             accept;
  logic             last_bit;
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] opb_init;

  // For subtraction, B is inverted on entry. The +1 comes from the initial carry.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_opb_init
    assign opb_init[gi] = b[gi] ^ sub;
  end

  assign accept   = (state_reg == IDLE) && in_valid;
  assign last_bit = (state_reg == RUN) && (count_reg == CNT_W'(WIDTH - 1));

  serial_add_full_adder u_fa (
    .x  (opa_reg[0]),
    .y  (opb_reg[0]),
    .ci (carry_reg),
    .s  (fa_sum),
    .co (fa_cout)
  );

  assign result_next = {fa_sum, result_reg};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: accept -> WIDTH bit cycles -> hold until consumed
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid)  state_next = RUN;
      RUN:  if (last_bit)  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the current state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // Serial datapath: load on accept, then shift one bit per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_reg    <= '0;
      opb_reg    <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      count_reg  <= '0;
    end else if (accept) begin
      opa_reg   <= a;
      opb_reg   <= opb_init;
      carry_reg <= sub ? 1'b1 : cin;
      count_reg <= '0;
    end else if (state_reg == RUN) begin
      opa_reg    <= opa_reg >> 1;
      opb_reg    <= opb_reg >> 1;
      result_reg <= result_next[WIDTH-1:1];
      carry_reg  <= fa_cout;
      count_reg  <= count_reg + CNT_W'(1);
    end
  end

  // Capture the finished word and final carry on the edge that processes the MSB
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else if (last_bit) begin
      sum_reg  <= result_next;
      cout_reg <= fa_cout;
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl. It drives a WIDTH=8 instance with
// directed and random stimulus and a WIDTH=4 instance with an exhaustive sweep.
module tb_serial_add_ctrl;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  logic          iv8, ir8, cin8, sub8, ov8, or8, cout8, busy8;
  logic [W8-1:0] a8, b8, sum8;
  logic          iv4, ir4, cin4, sub4, ov4, or4, cout4, busy4;
  logic [W4-1:0] a4, b4, sum4;

  serial_add_ctrl #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .sum(sum8),
    .cout(cout8), .busy(busy8)
  );

  serial_add_ctrl #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .cin(cin4), .sub(sub4), .out_valid(ov4), .out_ready(or4), .sum(sum4),
    .cout(cout4), .busy(busy4)
  );

  typedef struct {
    logic [31:0] s;
    logic        c;
    int          acc;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  int checks = 0;
  int failures = 0;
  logic ov8_prev = 1'b0;
  logic ov4_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain integer arithmetic modulo 2^w
  function automatic exp_t model(input int w, input int unsigned a, input int unsigned b,
                                 input bit cin, input bit sub, input int acc);
    exp_t e;
    longint unsigned m, t;
    m = 64'd1 << w;
    if (sub) begin
      t   = (longint'(a) + m - longint'(b)) % m;
      e.c = (a >= b);
    end else begin
      t   = longint'(a) + longint'(b) + longint'(cin);
      e.c = (t >= m);
      t   = t % m;
    end
    e.s   = t[31:0];
    e.acc = acc;
    return e;
  endfunction

  // Input monitor: record the expected result of every accepted operation
  always @(negedge clk) begin
    if (!rst && iv8 && ir8) q8.push_back(model(W8, a8, b8, cin8, sub8, cyc + 1));
    if (!rst && iv4 && ir4) q4.push_back(model(W4, a4, b4, cin4, sub4, cyc + 1));
  end

  // Output monitor, WIDTH=8: latency on the rising edge of out_valid, data at each handshake
  always @(negedge clk) begin
    if (rst) begin
      ov8_prev = 1'b0;
    end else begin
      if (ov8 && !ov8_prev) begin
        if (q8.size() == 0) chk("unexpected_valid8", 1, 0);
        else chk("latency8", cyc - q8[0].acc, W8);
        chk("busy8_done", busy8, 1);
      end
      if (ov8 && or8) begin
        if (q8.size() == 0) chk("unexpected_xfer8", 1, 0);
        else begin
          exp_t e;
          e = q8.pop_front();
          chk("sum8", sum8, e.s[W8-1:0]);
          chk("cout8", cout8, e.c);
        end
      end
      ov8_prev = ov8;
    end
  end

  // Output monitor, WIDTH=4
  always @(negedge clk) begin
    if (rst) begin
      ov4_prev = 1'b0;
    end else begin
      if (ov4 && !ov4_prev) begin
        if (q4.size() == 0) chk("unexpected_valid4", 1, 0);
        else chk("latency4", cyc - q4[0].acc, W4);
      end
      if (ov4 && or4) begin
        if (q4.size() == 0) chk("unexpected_xfer4", 1, 0);
        else begin
          exp_t e;
          e = q4.pop_front();
          chk("sum4", sum4, e.s[W4-1:0]);
          chk("cout4", cout4, e.c);
        end
      end
      ov4_prev = ov4;
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input bit c, input bit s);
    int n = 0;
    @(posedge clk); #1;
    a8 = a; b8 = b; cin8 = c; sub8 = s; iv8 = 1'b1;
    @(negedge clk);
    while (!ir8 && n < 200) begin @(negedge clk); n++; end
    chk("send8_ready", ir8, 1);
    @(posedge clk); #1;
    iv8 = 1'b0;
    // Scramble the inputs after the accept; the operation in flight must not notice.
    a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
    cin8 = 1'($urandom_range(0, 1)); sub8 = 1'($urandom_range(0, 1));
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input bit c, input bit s);
    int n = 0;
    @(posedge clk); #1;
    a4 = a; b4 = b; cin4 = c; sub4 = s; iv4 = 1'b1;
    @(negedge clk);
    while (!ir4 && n < 200) begin @(negedge clk); n++; end
    chk("send4_ready", ir4, 1);
    @(posedge clk); #1;
    iv4 = 1'b0;
  endtask

  task automatic drain8();
    int n = 0;
    @(negedge clk);
    while ((q8.size() != 0 || !ir8) && n < 500) begin @(negedge clk); n++; end
    chk("drain8", n < 500, 1);
  endtask

  task automatic drain4();
    int n = 0;
    @(negedge clk);
    while ((q4.size() != 0 || !ir4) && n < 500) begin @(negedge clk); n++; end
    chk("drain4", n < 500, 1);
  endtask

  initial begin
    bit rand_done;
    int n;
    rst = 1'b1;
    iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; or8 = 1;
    iv4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0; or4 = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", ir8, 1);
    chk("rst_out_valid", ov8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Directed arithmetic cases
    send8(8'h00, 8'h00, 0, 0); drain8();
    send8(8'hFF, 8'h01, 0, 0); drain8();
    send8(8'hFF, 8'h01, 1, 0); drain8();
    send8(8'd5,  8'd7,  1, 1); drain8();
    send8(8'd7,  8'd5,  0, 1); drain8();

    // Backpressure: result held for 5 cycles with out_ready low
    or8 = 1'b0;
    send8(8'h3C, 8'h0F, 0, 0);
    n = 0;
    @(negedge clk);
    while (!ov8 && n < 100) begin @(negedge clk); n++; end
    chk("bp_valid_seen", ov8, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", ov8, 1);
      chk("bp_sum_hold", sum8, 8'h4B);
      chk("bp_cout_hold", cout8, 0);
      chk("bp_in_ready_low", ir8, 0);
    end
    @(posedge clk); #1 or8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_in_ready_after", ir8, 1);
    chk("bp_valid_after", ov8, 0);
    drain8();

    // Input blocking: a new offer during RUN must be ignored
    send8(8'h12, 8'h34, 0, 0);
    repeat (2) @(posedge clk);
    #1 a8 = 8'hAA; b8 = 8'h55; sub8 = 1'b1; iv8 = 1'b1;
    @(negedge clk);
    chk("run_in_ready_low", ir8, 0);
    @(posedge clk); #1 iv8 = 1'b0;
    drain8();

    // Random operations with random output backpressure
    rand_done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++)
          send8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1 or8 = 1'($urandom_range(0, 1));
        end
        or8 = 1'b1;
      end
    join
    drain8();

    // Exhaustive 4-bit addition sweep
    for (int av = 0; av < 16; av++)
      for (int bv = 0; bv < 16; bv++)
        for (int cv = 0; cv < 2; cv++)
          send4(4'(av), 4'(bv), 1'(cv), 1'b0);
    drain4();

    // Reset three cycles into RUN
    send8(8'h11, 8'h22, 0, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    q8.delete();
    #1;
    chk("mid_rst_in_ready", ir8, 1);
    chk("mid_rst_out_valid", ov8, 0);
    chk("mid_rst_busy", busy8, 0);
    chk("mid_rst_sum", sum8, 0);
    chk("mid_rst_cout", cout8, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < W8 + 4; i++) begin
      @(negedge clk);
      chk("mid_rst_no_valid", ov8, 0);
    end
    send8(8'h80, 8'h80, 0, 0); drain8();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
